// File: rtl/byte_serial_adder32_pkg.sv
// rtl/byte_serial_adder32_pkg.sv - shared FSM state type and default sizing for the byte-serial adder
package byte_serial_adder32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_DEFAULT = 8;
    localparam int WIDTH_DEFAULT = 32;

endpackage

// File: rtl/prefix_add8.sv
// rtl/prefix_add8.sv - combinational Kogge-Stone slice adder with carry-in
module prefix_add8 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    localparam int LV = $clog2(W);

    logic [W-1:0] p0;
    logic [W-1:0] gv;
    logic [W-1:0] pv;
    logic [W-1:0] gn;
    logic [W-1:0] pn;

    assign p0 = a ^ b;

    // cin is folded into bit 0's generate so every prefix group carries it along
    always_comb begin
        gv    = a & b;
        pv    = p0;
        gn    = '0;
        pn    = '0;
        gv[0] = gv[0] | (pv[0] & cin);
        for (int l = 0; l < LV; l++) begin
            gn = gv;
            pn = pv;
            for (int i = (1 << l); i < W; i++) begin
                gn[i] = gv[i] | (pv[i] & gv[i - (1 << l)]);
                pn[i] = pv[i] & pv[i - (1 << l)];
            end
            gv = gn;
            pv = pn;
        end
        s    = p0 ^ {gv[W-2:0], cin};
        cout = gv[W-1];
    end

endmodule

// File: rtl/byte_serial_adder32.sv
// rtl/byte_serial_adder32.sv - slice-serial adder: one SLICE-bit prefix add per cycle, valid/ready handshakes
module byte_serial_adder32
    import byte_serial_adder32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int SLICE = SLICE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic [KW-1:0]    k;
    logic [SLICE-1:0] s_a;
    logic [SLICE-1:0] s_b;
    logic [SLICE-1:0] s_sum;
    logic             s_cout;
    logic             last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = carry;
    assign last      = (k == K_LAST);

    assign s_a = a_r[SLICE*int'(k) +: SLICE];
    assign s_b = b_r[SLICE*int'(k) +: SLICE];

    prefix_add8 #(.W(SLICE)) u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry),
        .s    (s_sum),
        .cout (s_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid)  state_n = ADD;
            ADD:     if (last)      state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // carry holds cin until slice 0 consumes it, then the running slice carry, then cout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            k     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        k     <= '0;
                    end
                end
                ADD: begin
                    sum_r[SLICE*int'(k) +: SLICE] <= s_sum;
                    carry <= s_cout;
                    k     <= last ? '0 : k + KW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_adder32.sv
// tb/tb_byte_serial_adder32.sv - scoreboard bench for byte_serial_adder32
module tb_byte_serial_adder32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    byte_serial_adder32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    function automatic logic [32:0] model(input logic [31:0] av, input logic [31:0] bv, input logic cv);
        return {1'b0, av} + {1'b0, bv} + {32'd0, cv};
    endfunction

    // called just after an edge with the DUT idle; operands are scrambled right after acceptance
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic [32:0] expv);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'b0;
    endtask

    // returns at the negedge where out_valid is first seen; lat counts edges since acceptance
    task automatic wait_result(output int lat);
        lat = 0;
        while (lat < 50) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    task automatic pop_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #12;
        total++;
        if ({in_ready, out_valid, sum, cout} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: got in_ready=%b out_valid=%b sum=%h cout=%b want 1 0 00000000 0",
                     in_ready, out_valid, sum, cout);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic        vc [3];
        logic [32:0] ve [3];
        logic [32:0] expv;
        int lat;
        va[0] = 32'h0000_0001; vb[0] = 32'h0000_0001; vc[0] = 1'b0; ve[0] = 33'h0_0000_0002;
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0000; vc[1] = 1'b1; ve[1] = 33'h1_0000_0000;
        va[2] = 32'h80FF_00FF; vb[2] = 32'h8001_0001; vc[2] = 1'b0; ve[2] = 33'h1_0100_0100;
        for (int n = 0; n < 3; n++) begin
            send(va[n], vb[n], vc[n], ve[n]);
            wait_result(lat);
            total++;
            if (lat !== 4) begin
                bad++;
                $display("FAIL basic%0d_latency: got %0d want 4", n, lat);
            end
            expv = exp_q.pop_front();
            total++;
            if ({cout, sum} !== expv) begin
                bad++;
                $display("FAIL basic%0d_result: got cout=%b sum=%h want cout=%b sum=%h",
                         n, cout, sum, expv[32], expv[31:0]);
            end
            pop_result();
        end
    endtask

    task automatic test_hold();
        logic [31:0] hs;
        logic        hc;
        logic [32:0] expv;
        int lat;
        int unstable = 0;
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, model(32'h1234_5678, 32'h9ABC_DEF0, 1'b1));
        wait_result(lat);
        hs = sum; hc = cout;
        expv = exp_q.pop_front();
        total++;
        if ({hc, hs} !== expv) begin
            bad++;
            $display("FAIL hold_result: got cout=%b sum=%h want cout=%b sum=%h", hc, hs, expv[32], expv[31:0]);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; cin = 1'b1; end
            if (i == 5) in_valid = 1'b0;
            @(posedge clk); @(negedge clk);
            if ({sum, cout, in_ready, out_valid} !== {hs, hc, 1'b0, 1'b1}) unstable++;
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable);
        end
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL hold_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic [32:0] expv;
        int lat;
        int seen = 0;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, model(32'hFFFF_FFFF, 32'h0000_0001, 1'b0));
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, sum, cout} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL abort_reset_outputs: got in_ready=%b out_valid=%b sum=%h cout=%b want 1 0 00000000 0",
                     in_ready, out_valid, sum, cout);
        end
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort_no_result: got out_valid high %0d cycles want 0", seen);
        end
        @(posedge clk); #1;
        send(32'd5, 32'd7, 1'b0, 33'd12);
        wait_result(lat);
        expv = exp_q.pop_front();
        total++;
        if (lat !== 4 || {cout, sum} !== expv) begin
            bad++;
            $display("FAIL abort_after: got lat=%0d cout=%b sum=%h want lat=4 cout=%b sum=%h",
                     lat, cout, sum, expv[32], expv[31:0]);
        end
        pop_result();
    endtask

    task automatic test_back_to_back();
        logic [31:0] av;
        logic [31:0] bv;
        logic        cv;
        logic [32:0] expv;
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int n = 0; n < 4; n++) begin
            av = $urandom; bv = $urandom; cv = 1'($urandom_range(0, 1));
            if (n == 0) begin av = 32'hFFFF_FF00; bv = 32'h0000_00FF; cv = 1'b1; end
            a = av; b = bv; cin = cv;
            exp_q.push_back(model(av, bv, cv));
            @(posedge clk); #1;
            a = ~av; b = $urandom; cin = ~cv;
            wait_result(lat);
            expv = exp_q.pop_front();
            total++;
            if (lat !== 4 || {cout, sum} !== expv) begin
                bad++;
                $display("FAIL b2b%0d: got lat=%0d cout=%b sum=%h want lat=4 cout=%b sum=%h",
                         n, lat, cout, sum, expv[32], expv[31:0]);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_serial_adder32.md
BYTE_SERIAL_ADDER32 -- requirements
Module: byte_serial_adder32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand width in bits; it SHALL be a multiple of SLICE.
REQ-002 SHALL have parameter SLICE, default 8, meaning the bits added per cycle.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-007 SHALL have port a, input, WIDTH bits: operand A.
REQ-008 SHALL have port b, input, WIDTH bits: operand B.
REQ-009 SHALL have port cin, input, 1 bit: carry-in to bit 0.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port sum, output, WIDTH bits: a+b+cin modulo 2^WIDTH.
REQ-013 SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.

Function
REQ-014 SHALL implement the FSM states IDLE, ADD and DONE.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 On in_valid&&in_ready at an edge, the block SHALL register a, b and cin, clear slice index k to 0, and go to ADD.
REQ-017 In ADD, each cycle SHALL compute slice k (bits k*SLICE+SLICE-1..k*SLICE) from the registered operands and the carry register.
REQ-018 In ADD, the block SHALL write the slice result into the sum register, store the slice carry-out into the carry register, and increment k.
REQ-019 After slice NSLICE-1 (NSLICE=WIDTH/SLICE; 4 by default), the block SHALL go to DONE, with cout equal to the final carry.
REQ-020 Latency SHALL be fixed: out_valid rises exactly NSLICE cycles after the acceptance edge, independent of the data values.
REQ-021 In DONE, out_valid SHALL be 1 and in_ready SHALL be 0.
REQ-022 In DONE, sum and cout SHALL hold stable while out_ready=0, for any number of cycles.
REQ-023 On out_valid&&out_ready, the block SHALL return to IDLE; new operands SHALL NOT be accepted in that same cycle.
REQ-024 in_valid asserted in ADD or DONE SHALL be ignored, and the registered operands SHALL NOT change.
REQ-025 Operands at a and b SHALL be sampled only at acceptance; later changes to them SHALL NOT affect the result.
REQ-026 Overflow SHALL wrap modulo 2^WIDTH, with the carry reported only on cout.
REQ-027 Each slice SHALL use parallel-prefix (generate/propagate) carry logic with a carry-in; no ripple chain SHALL exist across the slice.
REQ-028 The slice index counter SHALL be ceil(log2(NSLICE)) bits wide and SHALL never exceed NSLICE-1.

Reset
REQ-029 Asserting rst_n low SHALL, asynchronously, set the state to IDLE and clear the carry register and k.
REQ-030 Asserting rst_n low SHALL, asynchronously, drive sum=0, cout=0, out_valid=0 and in_ready=1.
REQ-031 Reset during ADD or DONE SHALL abort the operation without producing a result; the first accept after rst_n deasserts SHALL behave as from power-up.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, ADD, DONE) and the constants SLICE_DEFAULT=8 and WIDTH_DEFAULT=32.
REQ-033 One sub-module, prefix_add8, SHALL hold the combinational SLICE-bit prefix adder (inputs a, b, cin; outputs s, cout).
REQ-034 byte_serial_adder32 SHALL instantiate prefix_add8 exactly once.

Verification
REQ-035 The bench SHALL check: a=0x0000_0001, b=0x0000_0001, cin=0 -> sum=0x0000_0002, cout=0, out_valid exactly 4 cycles after accept.
REQ-036 The bench SHALL check: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, with the carry crossing all three slice boundaries.
REQ-037 The bench SHALL check: a=0x80FF_00FF, b=0x8001_0001, cin=0 -> sum=0x0100_0100, cout=1.
REQ-038 The bench SHALL check: out_ready held 0 for 10 cycles in DONE -> sum/cout stable, in_ready=0, and an in_valid pulse is ignored; then out_ready=1 -> IDLE next cycle.
REQ-039 The bench SHALL check: rst_n pulsed low during the 2nd ADD cycle -> out_valid never rises; then a=5, b=7, cin=0 -> sum=12, cout=0.
REQ-040 The bench SHALL check: back-to-back transactions with in_valid held high and a, b changed immediately after accept -> each result matches the operands sampled at its accept.
